// File: rtl/sysid_check.sv
// Reads the system ID and timestamp words from an Avalon-MM sysid slave and
// compares them against the build-time expected values.
module sysid_check #(
  parameter logic [31:0] EXPECTED_ID = 32'd1193057379,
  parameter logic [31:0] EXPECTED_TS = 32'd1330643110,
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter bit          AUTO_START  = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout,
  output logic [31:0] id_word,
  output logic [31:0] ts_word
);

  typedef enum logic [2:0] {
    IDLE,
    RD_ID,
    RD_TS,
    CHECK,
    FAIL_TO
  } state_t;

  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYC - 1);

  state_t      state;
  state_t      next_state;
  logic [15:0] wait_cnt;
  logic        auto_armed;
  logic        in_read;
  logic        wait_expired;

  always_comb begin
    in_read      = (state == RD_ID) || (state == RD_TS);
    wait_expired = avm_waitrequest && (wait_cnt == WAIT_LAST);
    next_state   = state;
    case (state)
      IDLE: begin
        if (start || (AUTO_START && auto_armed)) next_state = RD_ID;
      end
      RD_ID: begin
        if (!avm_waitrequest)  next_state = RD_TS;
        else if (wait_expired) next_state = FAIL_TO;
      end
      RD_TS: begin
        if (!avm_waitrequest)  next_state = CHECK;
        else if (wait_expired) next_state = FAIL_TO;
      end
      CHECK:   next_state = IDLE;
      FAIL_TO: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // The arm flag only survives the first clock after reset release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      auto_armed <= 1'b1;
      wait_cnt   <= '0;
    end else begin
      state      <= next_state;
      auto_armed <= 1'b0;
      if (next_state != state)
        wait_cnt <= '0;
      else if (in_read && avm_waitrequest)
        wait_cnt <= wait_cnt + 16'd1;
    end
  end

  // Bus strobes are decoded from next_state so they are registered and hold
  // steady for the whole time a read is stalled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      avm_read    <= 1'b0;
      avm_address <= 1'b0;
      done        <= 1'b0;
      id_ok       <= 1'b0;
      ts_ok       <= 1'b0;
      timeout     <= 1'b0;
      id_word     <= '0;
      ts_word     <= '0;
    end else begin
      avm_read    <= (next_state == RD_ID) || (next_state == RD_TS);
      avm_address <= (next_state == RD_TS);
      done        <= (state == CHECK) || (state == FAIL_TO);
      if (state == RD_ID && !avm_waitrequest) id_word <= avm_readdata;
      if (state == RD_TS && !avm_waitrequest) ts_word <= avm_readdata;
      if (state == CHECK) begin
        id_ok   <= (id_word == EXPECTED_ID);
        ts_ok   <= (ts_word == EXPECTED_TS);
        timeout <= 1'b0;
      end else if (state == FAIL_TO) begin
        id_ok   <= 1'b0;
        ts_ok   <= 1'b0;
        timeout <= 1'b1;
      end
    end
  end

  always_comb busy = (state != IDLE);

endmodule
